pulse_freq_meter: RTL and testbench

Measures the frequency of an external pulse train against a periodic gate tick, such as the 1 Hz tick from the board clock divider. It counts rising edges of an asynchronous input between consecutive gate ticks in a cascaded BCD accumulator. At each tick it latches the result for the seven-segment display path and emits a one-cycle valid strobe. It sits between the tick generator and the display/scoreboard logic.

---
 rtl/pulse_freq_meter_pkg.sv | 13 +
 rtl/pulse_freq_meter_bcd_digit_counter.sv | 36 +++
 rtl/pulse_freq_meter.sv | 111 +++++++++++
 tb/tb_pulse_freq_meter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_freq_meter_pkg.sv
// Shared constants and types for the pulse frequency meter.
package pulse_freq_meter_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
    localparam int unsigned DEFAULT_DIGITS = 4;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

endpackage

// File: rtl/pulse_freq_meter_bcd_digit_counter.sv
// One BCD digit of the edge accumulator: synchronous clear, enabled increment
// that wraps 9->0, and a ripple carry chain to the next digit.
module bcd_digit_counter
    import pulse_freq_meter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc_en,
    input  logic               carry_in,
    output logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] digit_inc,
    output logic               carry_out
);

    // digit_inc is the value this digit takes if the whole accumulator steps,
    // exposed so the top can latch the count including a same-cycle edge.
    always_comb begin
        carry_out = carry_in && (digit == DIGIT_MAX);
        digit_inc = digit;
        if (carry_out) begin
            digit_inc = '0;
        end else if (carry_in) begin
            digit_inc = digit + DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            digit <= '0;
        end else if (inc_en) begin
            digit <= digit_inc;
        end
    end

endmodule

// File: rtl/pulse_freq_meter.sv
// Counts synchronized rising edges of sig_in between gate ticks in a BCD
// accumulator and latches the per-window result with a one-cycle valid strobe.
module pulse_freq_meter
    import pulse_freq_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DIGITS      = DEFAULT_DIGITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      gate_tick,
    input  logic                      sig_in,
    output logic [DIGIT_W*DIGITS-1:0] count_bcd,
    output logic                      overflow,
    output logic                      valid
);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      sig_d_q;
    logic                      rise;
    state_t                    state_q, state_d;
    logic                      acc_clear, acc_inc_en, sat_hit, close_window;
    logic                      win_ovf_q;
    logic [DIGITS:0]           carry;
    logic [DIGIT_W*DIGITS-1:0] acc, acc_inc;
    logic                      all_nines;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] && !sig_d_q;

    // carry[0] is tied high: the chain always reports the would-be incremented
    // value, and inc_en decides whether the digits actually take it.
    assign carry[0]  = 1'b1;
    assign all_nines = carry[DIGITS];

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk       (clk),
            .reset     (reset),
            .clear     (acc_clear),
            .inc_en    (acc_inc_en),
            .carry_in  (carry[k]),
            .digit     (acc[k*DIGIT_W +: DIGIT_W]),
            .digit_inc (acc_inc[k*DIGIT_W +: DIGIT_W]),
            .carry_out (carry[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_clear    = 1'b1;
        acc_inc_en   = 1'b0;
        sat_hit      = 1'b0;
        close_window = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gate_tick) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                acc_clear    = gate_tick;
                acc_inc_en   = rise && !all_nines;
                sat_hit      = rise && all_nines;
                close_window = gate_tick;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || acc_clear) begin
            win_ovf_q <= 1'b0;
        end else if (sat_hit) begin
            win_ovf_q <= 1'b1;
        end
    end

    // An edge coinciding with the tick belongs to the closing window.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_bcd <= '0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= close_window;
            if (close_window) begin
                count_bcd <= acc_inc_en ? acc_inc : acc;
                overflow  <= win_ovf_q || sat_hit;
            end
        end
    end

endmodule

// File: tb/tb_pulse_freq_meter.sv
// Scoreboard bench for pulse_freq_meter: expected window results are queued at
// each tick and checked whenever valid is seen.
module tb_pulse_freq_meter;
    import pulse_freq_meter_pkg::*;

    logic        clk;
    logic        reset;
    logic        gate_tick;
    logic        sig_in;
    logic [15:0] count_bcd;
    logic        overflow;
    logic        valid;

    logic [16:0] exp_q[$];
    int          n_cmp;
    int          n_bad;
    int          pending;
    bit          in_measure;

    pulse_freq_meter #(
        .SYNC_STAGES (2),
        .DIGITS      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .gate_tick (gate_tick),
        .sig_in    (sig_in),
        .count_bcd (count_bcd),
        .overflow  (overflow),
        .valid     (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16:0] model(input int n);
        logic [15:0] b;
        int          v;
        if (n > 9999) return {1'b1, 16'h9999};
        v = n;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            b[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {1'b0, b};
    endfunction

    // One clock; any valid seen pops the scoreboard.
    task automatic step();
        logic [16:0] e;
        @(posedge clk);
        #1;
        if (valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: got count=%h ovf=%0b, required no strobe",
                         count_bcd, overflow);
            end else begin
                e = exp_q.pop_front();
                if ({overflow, count_bcd} !== e) begin
                    n_bad++;
                    $display("FAIL window_result: got count=%h ovf=%0b, required count=%h ovf=%0b",
                             count_bcd, overflow, e[15:0], e[16]);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            idle(2);
            sig_in = 1'b0;
            idle(2);
        end
        pending += n;
    endtask

    task automatic tick();
        gate_tick = 1'b1;
        if (in_measure) exp_q.push_back(model(pending));
        pending    = 0;
        in_measure = 1'b1;
        step();
        gate_tick = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [15:0] c, input logic o);
        n_cmp++;
        if (count_bcd !== c || overflow !== o) begin
            n_bad++;
            $display("FAIL %s: got count=%h ovf=%0b, required count=%h ovf=%0b",
                     name, count_bcd, overflow, c, o);
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected strobes never seen, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %0b, required 0", valid);
        end
        check_out("reset_outputs", 16'h0000, 1'b0);
        reset      = 1'b0;
        pending    = 0;
        in_measure = 1'b0;
        edges(10);
        idle(3);
        tick();
        idle(2);
        check_out("first_tick_no_result", 16'h0000, 1'b0);
        n_cmp++;
        if (dut.state_q !== MEASURE) begin
            n_bad++;
            $display("FAIL first_tick_state: got %0d, required %0d", dut.state_q, MEASURE);
        end
        check_drained("first_tick_strobes");
    endtask

    task automatic test_basic();
        tick();
        edges(37);
        idle(5);
        tick();
        check_drained("basic_strobe");
        idle(10);
        check_out("basic_hold", 16'h0037, 1'b0);
    endtask

    task automatic test_overflow();
        tick();
        edges(10005);
        idle(5);
        tick();
        check_drained("overflow_strobe");
        check_out("overflow_hold", 16'h9999, 1'b1);
        edges(5);
        idle(5);
        tick();
        check_drained("after_overflow_strobe");
        check_out("after_overflow_hold", 16'h0005, 1'b0);
    endtask

    task automatic test_coincident_edge();
        tick();
        edges(11);
        idle(5);
        sig_in = 1'b1;
        idle(2);
        pending += 1;
        tick();
        idle(1);
        sig_in = 1'b0;
        idle(96);
        tick();
        check_drained("coincident_strobes");
        check_out("empty_window", 16'h0000, 1'b0);
    endtask

    task automatic test_reset_mid_window();
        tick();
        edges(20);
        idle(5);
        tick();
        edges(20);
        reset = 1'b1;
        step();
        reset      = 1'b0;
        pending    = 0;
        in_measure = 1'b0;
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_valid: got %0b, required 0", valid);
        end
        check_out("midreset_outputs", 16'h0000, 1'b0);
        edges(3);
        idle(5);
        tick();
        idle(2);
        check_drained("midreset_no_strobe");
        edges(3);
        idle(5);
        tick();
        check_drained("after_midreset_strobe");
        check_out("after_midreset_hold", 16'h0003, 1'b0);
    endtask

    task automatic test_back_to_back();
        edges(4);
        idle(5);
        gate_tick = 1'b1;
        exp_q.push_back(model(pending));
        step();
        exp_q.push_back(model(0));
        n_cmp++;
        if (exp_q.size() != 1) begin
            n_bad++;
            $display("FAIL b2b_first_latency: %0d pending, required 1", exp_q.size());
        end
        step();
        gate_tick = 1'b0;
        pending   = 0;
        check_drained("b2b_second_latency");
        check_out("b2b_second_value", 16'h0000, 1'b0);
        idle(3);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        pending    = 0;
        in_measure = 1'b0;
        reset      = 1'b1;
        gate_tick  = 1'b0;
        sig_in     = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_coincident_edge();
        test_reset_mid_window();
        test_back_to_back();
        check_drained("final_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
